wb_to_axi4_bridge: RTL and testbench
====================================

WB_TO_AXI4_BRIDGE -- requirements
Module: wb_to_axi4_bridge

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32: Wishbone and AXI address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32: data width; legal values 32 and 64.
REQ-003 The block SHALL have parameter ID_WIDTH, default 4: AXI ID width.
REQ-004 The block SHALL have parameter AXI_ID, default 0: constant ID driven on awid and arid.
REQ-005 The block SHALL have port ACLK, input, 1 bit: clock.
REQ-006 The block SHALL have port ARESETN, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port i_wb_adr, input, ADDR_WIDTH bits: byte address.
REQ-008 The block SHALL have ports i_wb_dat (input, DATA_WIDTH bits) and i_wb_sel (input, DATA_WIDTH/8 bits): write data and byte selects.
REQ-009 The block SHALL have ports i_wb_we, i_wb_cyc and i_wb_stb, input, 1 bit each: Wishbone classic control.
REQ-010 The block SHALL have ports o_wb_rdt (output, DATA_WIDTH bits), o_wb_ack (output, 1 bit) and o_wb_err (output, 1 bit): read data and termination.
REQ-011 The block SHALL have AXI4 master write-address outputs M_AXI_aw{id,addr,len[8],size[3],burst[2],lock[2],cache[4],prot[3],qos[4],region[4],valid}, with input M_AXI_awready.
REQ-012 The block SHALL have write-data outputs M_AXI_w{data,strb,last,valid}, with input M_AXI_wready.
REQ-013 The block SHALL have write-response inputs M_AXI_b{id,resp[2],valid}, with output M_AXI_bready.
REQ-014 The block SHALL have read-address outputs M_AXI_ar* with the same field set as the AW channel, with input M_AXI_arready.
REQ-015 The block SHALL have read-data inputs M_AXI_r{id,data,resp[2],last,valid}, with output M_AXI_rready.

Function
REQ-016 The block SHALL issue one single-beat AXI4 transaction per Wishbone request.
  - len = 0, size = log2(DATA_WIDTH/8), burst = INCR (01), wlast = 1.
  - lock, cache, prot, qos and region = 0.
REQ-017 The FSM SHALL have states IDLE, WR (AW and W pending), B_WAIT, RD (AR pending), R_WAIT and DONE.
REQ-018 In IDLE, when i_wb_cyc & i_wb_stb & !o_wb_ack, the block SHALL:
  - capture address (low log2(DATA_WIDTH/8) bits forced to 0), data, sel and we;
  - move to WR if we = 1, else to RD;
  - assert the corresponding valid(s) on the next cycle.
REQ-019 In WR, awvalid and wvalid SHALL both assert together.
  - Each SHALL deassert independently after its own handshake (awready and wready in any order, including the same cycle).
  - The FSM SHALL move to B_WAIT only once both handshakes are done.
REQ-020 In B_WAIT, bready SHALL be 1; on bvalid the block SHALL go to DONE and register err = resp[1].
REQ-021 In RD, arvalid SHALL stay 1 until arready, then the FSM SHALL move to R_WAIT.
REQ-022 In R_WAIT, rready SHALL be 1; on rvalid the block SHALL register rdata into o_wb_rdt and err = resp[1], then go to DONE.
REQ-023 In DONE, the block SHALL pulse o_wb_ack (err = 0) or o_wb_err (err = 1) for exactly one cycle, then return to IDLE.
  - o_wb_rdt SHALL hold its value until the next read completes.
REQ-024 Every valid SHALL be held stable with unchanged payload until its handshake completes; no valid SHALL depend combinationally on a ready.
REQ-025 Abort: if i_wb_cyc drops while outstanding, the AXI transaction SHALL still complete, and the DONE pulse SHALL be suppressed.
REQ-026 Minimum latency SHALL be as follows, with the slave responding with zero wait:
  - write: request cycle 0, valids cycle 1, bvalid no earlier than cycle 2, ack on the cycle after the B handshake;
  - read: ack on the cycle after the R handshake.
REQ-027 The block SHALL ignore bid, rid and rlast, and SHALL have no error path for them.
REQ-028 The block SHALL have at most one outstanding transaction; new requests SHALL be accepted only in IDLE.

Reset
REQ-029 Assertion of ARESETN SHALL force the following, asynchronously, including mid-transaction:
  - state = IDLE;
  - all valid, ready, ack and err outputs = 0;
  - o_wb_rdt = 0 and captured registers = 0.
REQ-030 After reset release, the first request SHALL be accepted on the first rising edge with cyc & stb.

Structure
REQ-031 The state encoding, AXI burst/resp constants (INCR = 01, OKAY = 00, SLVERR = 10, DECERR = 11) and the size function SHALL live in a shared package, axi_pkg.
REQ-032 The design SHALL be a single module with no sub-modules; the AW/W done flags SHALL be local registers.

Verification
REQ-033 Write test: WB write adr = 0x0000_0010, dat = 0xDEADBEEF, sel = 0xF to a zero-wait slave -> awaddr = 0x10, wdata = 0xDEADBEEF, wstrb = 0xF, wlast = 1, one o_wb_ack pulse, no err.
REQ-034 Read-back test: WB read adr = 0x13 -> araddr = 0x10, rdata 0xDEADBEEF returned, o_wb_rdt = 0xDEADBEEF with ack.
REQ-035 Handshake-order test: awready delayed 3 cycles, wready immediate, then the reverse -> each valid drops only after its own handshake, exactly one AW and one W per request.
REQ-036 Error test: slave returns bresp = 10 on a write and rresp = 11 on a read -> o_wb_err pulses once, o_wb_ack stays 0.
REQ-037 Abort test: cyc drops while in B_WAIT -> bready still completes the handshake, no ack, and the next request proceeds normally.
REQ-038 Reset test: ARESETN asserted while arvalid = 1 -> arvalid = 0 immediately, state IDLE, no ack after release.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the FSM state type for the Wishbone-to-AXI4 bridge.
package axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR     = 3'd1,
    ST_B_WAIT = 3'd2,
    ST_RD     = 3'd3,
    ST_R_WAIT = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // AxSIZE for a full-width beat: log2 of the bus width in bytes.
  function automatic logic [2:0] axi_size(input int unsigned data_width);
    return 3'($clog2(data_width / 8));
  endfunction

  function automatic logic resp_is_err(input logic [1:0] resp);
    logic err;
    case (resp)
      RESP_OKAY, RESP_EXOKAY:   err = 1'b0;
      RESP_SLVERR, RESP_DECERR: err = 1'b1;
      default:                  err = 1'b0;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/wb_to_axi4_bridge.sv
// Wishbone classic slave to AXI4 master: one single-beat AXI transaction per
// Wishbone request, at most one outstanding.
module wb_to_axi4_bridge
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int AXI_ID     = 0
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,

  input  logic [ADDR_WIDTH-1:0]   i_wb_adr,
  input  logic [DATA_WIDTH-1:0]   i_wb_dat,
  input  logic [DATA_WIDTH/8-1:0] i_wb_sel,
  input  logic                    i_wb_we,
  input  logic                    i_wb_cyc,
  input  logic                    i_wb_stb,
  output logic [DATA_WIDTH-1:0]   o_wb_rdt,
  output logic                    o_wb_ack,
  output logic                    o_wb_err,

  output logic [ID_WIDTH-1:0]     M_AXI_awid,
  output logic [ADDR_WIDTH-1:0]   M_AXI_awaddr,
  output logic [7:0]              M_AXI_awlen,
  output logic [2:0]              M_AXI_awsize,
  output logic [1:0]              M_AXI_awburst,
  output logic [1:0]              M_AXI_awlock,
  output logic [3:0]              M_AXI_awcache,
  output logic [2:0]              M_AXI_awprot,
  output logic [3:0]              M_AXI_awqos,
  output logic [3:0]              M_AXI_awregion,
  output logic                    M_AXI_awvalid,
  input  logic                    M_AXI_awready,

  output logic [DATA_WIDTH-1:0]   M_AXI_wdata,
  output logic [DATA_WIDTH/8-1:0] M_AXI_wstrb,
  output logic                    M_AXI_wlast,
  output logic                    M_AXI_wvalid,
  input  logic                    M_AXI_wready,

  input  logic [ID_WIDTH-1:0]     M_AXI_bid,
  input  logic [1:0]              M_AXI_bresp,
  input  logic                    M_AXI_bvalid,
  output logic                    M_AXI_bready,

  output logic [ID_WIDTH-1:0]     M_AXI_arid,
  output logic [ADDR_WIDTH-1:0]   M_AXI_araddr,
  output logic [7:0]              M_AXI_arlen,
  output logic [2:0]              M_AXI_arsize,
  output logic [1:0]              M_AXI_arburst,
  output logic [1:0]              M_AXI_arlock,
  output logic [3:0]              M_AXI_arcache,
  output logic [2:0]              M_AXI_arprot,
  output logic [3:0]              M_AXI_arqos,
  output logic [3:0]              M_AXI_arregion,
  output logic                    M_AXI_arvalid,
  input  logic                    M_AXI_arready,

  input  logic [ID_WIDTH-1:0]     M_AXI_rid,
  input  logic [DATA_WIDTH-1:0]   M_AXI_rdata,
  input  logic [1:0]              M_AXI_rresp,
  input  logic                    M_AXI_rlast,
  input  logic                    M_AXI_rvalid,
  output logic                    M_AXI_rready
);

  localparam int                    STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [2:0]            AXI_SIZE   = axi_size(DATA_WIDTH);
  localparam logic [ID_WIDTH-1:0]   ID_VALUE   = ID_WIDTH'(AXI_ID);
  localparam logic [ADDR_WIDTH-1:0] ADR_MASK   = ~(ADDR_WIDTH'(STRB_WIDTH - 1));

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;
  logic [STRB_WIDTH-1:0]   sel_q, sel_d;
  logic                    we_q, we_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic                    err_q, err_d;
  logic                    abort_q, abort_d;
  logic [DATA_WIDTH-1:0]   rdt_q, rdt_d;
  logic                    accept;

  // IDs and rlast carry no information for a single-outstanding, single-beat master.
  logic unused_axi_fields;
  assign unused_axi_fields = ^{M_AXI_bid, M_AXI_rid, M_AXI_rlast};

  assign accept = (state_q == ST_IDLE) && i_wb_cyc && i_wb_stb && !o_wb_ack;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = i_wb_we ? ST_WR : ST_RD;
      ST_WR:     if ((aw_done_q || M_AXI_awready) && (w_done_q || M_AXI_wready))
                   state_d = ST_B_WAIT;
      ST_B_WAIT: if (M_AXI_bvalid) state_d = ST_DONE;
      ST_RD:     if (M_AXI_arready) state_d = ST_R_WAIT;
      ST_R_WAIT: if (M_AXI_rvalid) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Valids come only from registered state, never from a ready.
  always_comb begin
    M_AXI_awvalid = 1'b0;
    M_AXI_wvalid  = 1'b0;
    M_AXI_bready  = 1'b0;
    M_AXI_arvalid = 1'b0;
    M_AXI_rready  = 1'b0;
    o_wb_ack      = 1'b0;
    o_wb_err      = 1'b0;
    case (state_q)
      ST_WR: begin
        M_AXI_awvalid = !aw_done_q;
        M_AXI_wvalid  = !w_done_q;
      end
      ST_B_WAIT: M_AXI_bready  = 1'b1;
      ST_RD:     M_AXI_arvalid = 1'b1;
      ST_R_WAIT: M_AXI_rready  = 1'b1;
      ST_DONE: begin
        o_wb_ack = !abort_q && !err_q;
        o_wb_err = !abort_q &&  err_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    we_d      = we_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    err_d     = err_q;
    abort_d   = abort_q;
    rdt_d     = rdt_q;

    if (accept) begin
      adr_d     = i_wb_adr & ADR_MASK;
      dat_d     = i_wb_dat;
      sel_d     = i_wb_sel;
      we_d      = i_wb_we;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
      err_d     = 1'b0;
      abort_d   = 1'b0;
    end

    if (state_q == ST_WR) begin
      if (M_AXI_awready) aw_done_d = 1'b1;
      if (M_AXI_wready)  w_done_d  = 1'b1;
    end

    if (state_q == ST_B_WAIT && M_AXI_bvalid) err_d = resp_is_err(M_AXI_bresp);

    if (state_q == ST_R_WAIT && M_AXI_rvalid) begin
      err_d = resp_is_err(M_AXI_rresp);
      if (!we_q) rdt_d = M_AXI_rdata;
    end

    // A dropped cycle lets the AXI side finish but silences the Wishbone termination.
    if (!i_wb_cyc && (state_q == ST_WR || state_q == ST_B_WAIT ||
                      state_q == ST_RD || state_q == ST_R_WAIT))
      abort_d = 1'b1;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
      abort_q   <= 1'b0;
      rdt_q     <= '0;
    end else begin
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      err_q     <= err_d;
      abort_q   <= abort_d;
      rdt_q     <= rdt_d;
    end
  end

  assign o_wb_rdt       = rdt_q;

  assign M_AXI_awid     = ID_VALUE;
  assign M_AXI_awaddr   = adr_q;
  assign M_AXI_awlen    = 8'd0;
  assign M_AXI_awsize   = AXI_SIZE;
  assign M_AXI_awburst  = BURST_INCR;
  assign M_AXI_awlock   = 2'b00;
  assign M_AXI_awcache  = 4'h0;
  assign M_AXI_awprot   = 3'h0;
  assign M_AXI_awqos    = 4'h0;
  assign M_AXI_awregion = 4'h0;

  assign M_AXI_wdata    = dat_q;
  assign M_AXI_wstrb    = sel_q;
  assign M_AXI_wlast    = 1'b1;

  assign M_AXI_arid     = ID_VALUE;
  assign M_AXI_araddr   = adr_q;
  assign M_AXI_arlen    = 8'd0;
  assign M_AXI_arsize   = AXI_SIZE;
  assign M_AXI_arburst  = BURST_INCR;
  assign M_AXI_arlock   = 2'b00;
  assign M_AXI_arcache  = 4'h0;
  assign M_AXI_arprot   = 3'h0;
  assign M_AXI_arqos    = 4'h0;
  assign M_AXI_arregion = 4'h0;

endmodule

// File: tb/tb_wb_to_axi4_bridge.sv
// Scoreboard bench for wb_to_axi4_bridge: directed Wishbone requests against a
// configurable-latency AXI slave; expectations are queued at issue time.
module tb_wb_to_axi4_bridge;

  typedef struct packed {
    logic        err;
    logic [31:0] rdt;
  } wb_exp_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } w_exp_t;

  // len, size, burst, lock, cache, prot, qos, region, id for a 32-bit single beat
  localparam logic [33:0] AX_FIELDS = {8'h00, 3'd2, 2'b01, 2'b00, 4'h0, 3'h0, 4'h0, 4'h0, 4'h0};

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [31:0] i_wb_adr = '0;
  logic [31:0] i_wb_dat = '0;
  logic [3:0]  i_wb_sel = '0;
  logic        i_wb_we = 1'b0, i_wb_cyc = 1'b0, i_wb_stb = 1'b0;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack, o_wb_err;

  logic [3:0]  M_AXI_awid, M_AXI_arid;
  logic [31:0] M_AXI_awaddr, M_AXI_araddr;
  logic [7:0]  M_AXI_awlen, M_AXI_arlen;
  logic [2:0]  M_AXI_awsize, M_AXI_arsize, M_AXI_awprot, M_AXI_arprot;
  logic [1:0]  M_AXI_awburst, M_AXI_arburst, M_AXI_awlock, M_AXI_arlock;
  logic [3:0]  M_AXI_awcache, M_AXI_arcache, M_AXI_awqos, M_AXI_arqos;
  logic [3:0]  M_AXI_awregion, M_AXI_arregion;
  logic        M_AXI_awvalid, M_AXI_awready;
  logic [31:0] M_AXI_wdata;
  logic [3:0]  M_AXI_wstrb;
  logic        M_AXI_wlast, M_AXI_wvalid, M_AXI_wready;
  logic [3:0]  M_AXI_bid;
  logic [1:0]  M_AXI_bresp;
  logic        M_AXI_bvalid, M_AXI_bready;
  logic        M_AXI_arvalid, M_AXI_arready;
  logic [3:0]  M_AXI_rid;
  logic [31:0] M_AXI_rdata;
  logic [1:0]  M_AXI_rresp;
  logic        M_AXI_rlast, M_AXI_rvalid, M_AXI_rready;

  always #5 ACLK = ~ACLK;

  wb_to_axi4_bridge dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel),
    .i_wb_we(i_wb_we), .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb),
    .o_wb_rdt(o_wb_rdt), .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err),
    .M_AXI_awid(M_AXI_awid), .M_AXI_awaddr(M_AXI_awaddr), .M_AXI_awlen(M_AXI_awlen),
    .M_AXI_awsize(M_AXI_awsize), .M_AXI_awburst(M_AXI_awburst), .M_AXI_awlock(M_AXI_awlock),
    .M_AXI_awcache(M_AXI_awcache), .M_AXI_awprot(M_AXI_awprot), .M_AXI_awqos(M_AXI_awqos),
    .M_AXI_awregion(M_AXI_awregion), .M_AXI_awvalid(M_AXI_awvalid), .M_AXI_awready(M_AXI_awready),
    .M_AXI_wdata(M_AXI_wdata), .M_AXI_wstrb(M_AXI_wstrb), .M_AXI_wlast(M_AXI_wlast),
    .M_AXI_wvalid(M_AXI_wvalid), .M_AXI_wready(M_AXI_wready),
    .M_AXI_bid(M_AXI_bid), .M_AXI_bresp(M_AXI_bresp), .M_AXI_bvalid(M_AXI_bvalid),
    .M_AXI_bready(M_AXI_bready),
    .M_AXI_arid(M_AXI_arid), .M_AXI_araddr(M_AXI_araddr), .M_AXI_arlen(M_AXI_arlen),
    .M_AXI_arsize(M_AXI_arsize), .M_AXI_arburst(M_AXI_arburst), .M_AXI_arlock(M_AXI_arlock),
    .M_AXI_arcache(M_AXI_arcache), .M_AXI_arprot(M_AXI_arprot), .M_AXI_arqos(M_AXI_arqos),
    .M_AXI_arregion(M_AXI_arregion), .M_AXI_arvalid(M_AXI_arvalid), .M_AXI_arready(M_AXI_arready),
    .M_AXI_rid(M_AXI_rid), .M_AXI_rdata(M_AXI_rdata), .M_AXI_rresp(M_AXI_rresp),
    .M_AXI_rlast(M_AXI_rlast), .M_AXI_rvalid(M_AXI_rvalid), .M_AXI_rready(M_AXI_rready)
  );

  int total = 0;
  int bad = 0;

  wb_exp_t     wb_q[$];
  logic [31:0] aw_q[$];
  logic [31:0] ar_q[$];
  w_exp_t      w_q[$];

  // slave behaviour knobs
  int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [31:0] cfg_rdata = '0;
  int          aw_hs_cnt = 0, w_hs_cnt = 0, ar_hs_cnt = 0, b_hs_cnt = 0, r_hs_cnt = 0;
  int          resp_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // AXI slave: drives at the falling edge, so a ready/valid set here handshakes
  // on the next rising edge; B and R are evaluated before new AW/W/AR handshakes.
  initial begin : slave
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic aw_pend, w_pend, ar_pend, b_hs_next, r_hs_next;
    logic aw_wait, w_wait, ar_wait, aw_hs_prev, w_hs_prev, ar_hs_prev;
    logic [31:0] aw_hold, ar_hold;
    logic [35:0] w_hold;
    w_exp_t      we_exp;
    M_AXI_awready = 0; M_AXI_wready = 0; M_AXI_arready = 0;
    M_AXI_bvalid = 0; M_AXI_bresp = 0; M_AXI_bid = 4'h5;
    M_AXI_rvalid = 0; M_AXI_rresp = 0; M_AXI_rdata = '0; M_AXI_rlast = 0; M_AXI_rid = 4'h9;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    aw_pend = 0; w_pend = 0; ar_pend = 0; b_hs_next = 0; r_hs_next = 0;
    aw_wait = 0; w_wait = 0; ar_wait = 0; aw_hs_prev = 0; w_hs_prev = 0; ar_hs_prev = 0;
    aw_hold = '0; ar_hold = '0; w_hold = '0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        M_AXI_awready = 0; M_AXI_wready = 0; M_AXI_arready = 0;
        M_AXI_bvalid = 0; M_AXI_rvalid = 0; M_AXI_rlast = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        aw_pend = 0; w_pend = 0; ar_pend = 0; b_hs_next = 0; r_hs_next = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; aw_hs_prev = 0; w_hs_prev = 0; ar_hs_prev = 0;
      end else begin
        // write response
        if (b_hs_next) begin M_AXI_bvalid = 0; b_hs_next = 0; end
        if (!M_AXI_bvalid && aw_pend && w_pend) begin
          if (b_cnt >= b_delay) begin
            M_AXI_bvalid = 1; M_AXI_bresp = cfg_bresp; aw_pend = 0; w_pend = 0; b_cnt = 0;
          end else b_cnt++;
        end
        if (M_AXI_bvalid && M_AXI_bready) begin b_hs_next = 1; b_hs_cnt++; end
        // read data
        if (r_hs_next) begin M_AXI_rvalid = 0; M_AXI_rlast = 0; r_hs_next = 0; end
        if (!M_AXI_rvalid && ar_pend) begin
          if (r_cnt >= r_delay) begin
            M_AXI_rvalid = 1; M_AXI_rlast = 1; M_AXI_rdata = cfg_rdata; M_AXI_rresp = cfg_rresp;
            ar_pend = 0; r_cnt = 0;
          end else r_cnt++;
        end
        if (M_AXI_rvalid && M_AXI_rready) begin r_hs_next = 1; r_hs_cnt++; end

        // write address
        if (aw_hs_prev) check("awvalid_drops_after_hs", M_AXI_awvalid, 0);
        if (aw_wait) begin
          check("awvalid_held", M_AXI_awvalid, 1);
          check("awaddr_stable", M_AXI_awaddr, aw_hold);
        end
        aw_wait = 0; aw_hs_prev = 0; M_AXI_awready = 0;
        if (M_AXI_awvalid) begin
          if (aw_cnt >= aw_delay) begin
            M_AXI_awready = 1; aw_cnt = 0; aw_hs_cnt++; aw_pend = 1; aw_hs_prev = 1;
            check("aw_expected", 64'(aw_q.size() > 0), 1);
            if (aw_q.size() > 0) check("awaddr", M_AXI_awaddr, aw_q.pop_front());
            check("aw_fields", {M_AXI_awlen, M_AXI_awsize, M_AXI_awburst, M_AXI_awlock, M_AXI_awcache,
                                M_AXI_awprot, M_AXI_awqos, M_AXI_awregion, M_AXI_awid}, AX_FIELDS);
          end else begin
            aw_cnt++; aw_wait = 1; aw_hold = M_AXI_awaddr;
          end
        end else aw_cnt = 0;

        // write data
        if (w_hs_prev) check("wvalid_drops_after_hs", M_AXI_wvalid, 0);
        if (w_wait) begin
          check("wvalid_held", M_AXI_wvalid, 1);
          check("wdata_stable", {M_AXI_wdata, M_AXI_wstrb}, w_hold);
        end
        w_wait = 0; w_hs_prev = 0; M_AXI_wready = 0;
        if (M_AXI_wvalid) begin
          if (w_cnt >= w_delay) begin
            M_AXI_wready = 1; w_cnt = 0; w_hs_cnt++; w_pend = 1; w_hs_prev = 1;
            check("w_expected", 64'(w_q.size() > 0), 1);
            if (w_q.size() > 0) begin
              we_exp = w_q.pop_front();
              check("w_beat", {M_AXI_wdata, M_AXI_wstrb, M_AXI_wlast}, {we_exp.data, we_exp.strb, 1'b1});
            end
          end else begin
            w_cnt++; w_wait = 1; w_hold = {M_AXI_wdata, M_AXI_wstrb};
          end
        end else w_cnt = 0;

        // read address
        if (ar_hs_prev) check("arvalid_drops_after_hs", M_AXI_arvalid, 0);
        if (ar_wait) begin
          check("arvalid_held", M_AXI_arvalid, 1);
          check("araddr_stable", M_AXI_araddr, ar_hold);
        end
        ar_wait = 0; ar_hs_prev = 0; M_AXI_arready = 0;
        if (M_AXI_arvalid) begin
          if (ar_cnt >= ar_delay) begin
            M_AXI_arready = 1; ar_cnt = 0; ar_hs_cnt++; ar_pend = 1; ar_hs_prev = 1;
            check("ar_expected", 64'(ar_q.size() > 0), 1);
            if (ar_q.size() > 0) check("araddr", M_AXI_araddr, ar_q.pop_front());
            check("ar_fields", {M_AXI_arlen, M_AXI_arsize, M_AXI_arburst, M_AXI_arlock, M_AXI_arcache,
                                M_AXI_arprot, M_AXI_arqos, M_AXI_arregion, M_AXI_arid}, AX_FIELDS);
          end else begin
            ar_cnt++; ar_wait = 1; ar_hold = M_AXI_araddr;
          end
        end else ar_cnt = 0;
      end
    end
  end

  // Wishbone response monitor
  initial begin : monitor
    wb_exp_t e;
    forever begin
      @(negedge ACLK);
      if (ARESETN && (o_wb_ack || o_wb_err)) begin
        resp_cnt++;
        check("wb_resp_expected", 64'(wb_q.size() > 0), 1);
        if (wb_q.size() > 0) begin
          e = wb_q.pop_front();
          check("wb_ack_err", {o_wb_ack, o_wb_err}, {~e.err, e.err});
          check("wb_rdt", o_wb_rdt, e.rdt);
        end
      end
    end
  end

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [31:0] exp_addr,
                         input logic exp_err, input logic [31:0] exp_rdt, input int exp_lat);
    int n;
    logic seen;
    if (we) begin
      aw_q.push_back(exp_addr);
      w_q.push_back('{data: dat, strb: sel});
    end else begin
      ar_q.push_back(exp_addr);
    end
    wb_q.push_back('{err: exp_err, rdt: exp_rdt});
    @(negedge ACLK);
    i_wb_adr = adr; i_wb_dat = dat; i_wb_sel = sel; i_wb_we = we;
    i_wb_cyc = 1; i_wb_stb = 1;
    n = 0; seen = 0;
    while (!seen && n < 100) begin
      @(negedge ACLK);
      n++;
      seen = o_wb_ack | o_wb_err;
    end
    i_wb_cyc = 0; i_wb_stb = 0; i_wb_we = 0;
    check("wb_terminated", seen, 1);
    check("wb_latency", n, exp_lat);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int a0, w0, b0, r0, n;
    #12;
    check("rst_outputs", {M_AXI_awvalid, M_AXI_wvalid, M_AXI_bready, M_AXI_arvalid,
                          M_AXI_rready, o_wb_ack, o_wb_err}, 7'b0);
    check("rst_rdt", o_wb_rdt, 0);
    #10 ARESETN = 1;

    // basic write then read-back with a zero-wait slave
    wb_xfer(1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h10, 0, 32'h0, 3);
    cfg_rdata = 32'hDEAD_BEEF;
    wb_xfer(0, 32'h0000_0013, 32'h0, 4'h0, 32'h10, 0, 32'hDEAD_BEEF, 3);

    // handshake order: AW late, then W late
    a0 = aw_hs_cnt; w0 = w_hs_cnt;
    aw_delay = 3;
    wb_xfer(1, 32'h0000_0024, 32'h1234_5678, 4'h3, 32'h24, 0, 32'hDEAD_BEEF, 6);
    check("order1_aw_count", aw_hs_cnt - a0, 1);
    check("order1_w_count", w_hs_cnt - w0, 1);
    a0 = aw_hs_cnt; w0 = w_hs_cnt;
    aw_delay = 0; w_delay = 3;
    wb_xfer(1, 32'h0000_003C, 32'hA5A5_5A5A, 4'hC, 32'h3C, 0, 32'hDEAD_BEEF, 6);
    check("order2_aw_count", aw_hs_cnt - a0, 1);
    check("order2_w_count", w_hs_cnt - w0, 1);
    w_delay = 0;

    // error responses
    cfg_bresp = 2'b10;
    wb_xfer(1, 32'h0000_0040, 32'h0000_0001, 4'h1, 32'h40, 1, 32'hDEAD_BEEF, 3);
    cfg_bresp = 2'b00;
    cfg_rresp = 2'b11; cfg_rdata = 32'h0BAD_F00D;
    wb_xfer(0, 32'h0000_0047, 32'h0, 4'h0, 32'h44, 1, 32'h0BAD_F00D, 3);
    cfg_rresp = 2'b00;

    // abort while waiting for B
    b_delay = 3;
    aw_q.push_back(32'h50);
    w_q.push_back('{data: 32'h55, strb: 4'h1});
    @(negedge ACLK);
    i_wb_adr = 32'h50; i_wb_dat = 32'h55; i_wb_sel = 4'h1; i_wb_we = 1; i_wb_cyc = 1; i_wb_stb = 1;
    n = 0;
    while (!M_AXI_bready && n < 20) begin @(negedge ACLK); n++; end
    check("abort_reached_bwait", M_AXI_bready, 1);
    i_wb_cyc = 0; i_wb_stb = 0; i_wb_we = 0;
    b0 = b_hs_cnt; r0 = resp_cnt; n = 0;
    while (b_hs_cnt == b0 && n < 20) begin @(negedge ACLK); n++; end
    check("abort_b_handshake", b_hs_cnt - b0, 1);
    repeat (4) @(negedge ACLK);
    check("abort_no_ack", resp_cnt - r0, 0);
    b_delay = 0;
    cfg_rdata = 32'hCAFE_F00D;
    wb_xfer(0, 32'h0000_0010, 32'h0, 4'h0, 32'h10, 0, 32'hCAFE_F00D, 3);

    // asynchronous reset while AR is pending
    ar_delay = 10;
    @(negedge ACLK);
    i_wb_adr = 32'h80; i_wb_we = 0; i_wb_cyc = 1; i_wb_stb = 1;
    n = 0;
    while (!M_AXI_arvalid && n < 10) begin @(negedge ACLK); n++; end
    check("rst_arvalid_before", M_AXI_arvalid, 1);
    #2 ARESETN = 0;
    #1;
    check("rst_arvalid_async", M_AXI_arvalid, 0);
    check("rst_mid_outputs", {M_AXI_awvalid, M_AXI_wvalid, M_AXI_bready, M_AXI_rready,
                              o_wb_ack, o_wb_err}, 6'b0);
    check("rst_mid_rdt", o_wb_rdt, 0);
    i_wb_cyc = 0; i_wb_stb = 0;
    repeat (2) @(negedge ACLK);
    #2 ARESETN = 1;
    ar_delay = 0;
    r0 = resp_cnt;
    repeat (4) @(negedge ACLK);
    check("rst_no_ack_after", resp_cnt - r0, 0);
    wb_xfer(1, 32'h0000_0086, 32'h600D_CAFE, 4'h6, 32'h84, 0, 32'h0, 3);

    repeat (3) @(negedge ACLK);
    check("wb_q_drained", wb_q.size(), 0);
    check("aw_q_drained", aw_q.size(), 0);
    check("w_q_drained", w_q.size(), 0);
    check("ar_q_drained", ar_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
